// File: rtl/chan_link_fifo.sv
// Multi-lane drive-to-observe link: NUM_CH independent first-word-fall-through
// FIFOs with per-lane fill level and saturating observe-handshake counters.
module chan_link_fifo #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned CNT_W  = 8
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  flush,
    input  logic                                  cnt_clr,
    input  logic [NUM_CH-1:0]                     drv_valid,
    output logic [NUM_CH-1:0]                     drv_ready,
    input  logic [NUM_CH*DATA_W-1:0]              drv_data,
    output logic [NUM_CH-1:0]                     obs_valid,
    input  logic [NUM_CH-1:0]                     obs_ready,
    output logic [NUM_CH*DATA_W-1:0]              obs_data,
    output logic [NUM_CH*($clog2(DEPTH)+1)-1:0]   level,
    output logic [NUM_CH*CNT_W-1:0]               xfer_cnt
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
        logic [DATA_W-1:0] r_mem [DEPTH];
        logic [PTR_W-1:0]  r_wr_ptr;
        logic [PTR_W-1:0]  r_rd_ptr;
        logic [LVL_W-1:0]  r_level;
        logic [CNT_W-1:0]  r_cnt;
        logic              w_ready;
        logic              w_valid;
        logic              w_push;
        logic              w_pop;

        // Full/empty come from the level count so pointer equality is never ambiguous.
        assign w_ready = (r_level != LVL_W'(DEPTH)) && !flush;
        assign w_valid = (r_level != LVL_W'(0));
        assign w_push  = drv_valid[i] && w_ready;
        assign w_pop   = w_valid && obs_ready[i] && !flush;

        always_ff @(posedge clk) begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= drv_data[i*DATA_W +: DATA_W];
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_level  <= '0;
            end else if (flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_level  <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                end
                case ({w_push, w_pop})
                    2'b10:   r_level <= r_level + LVL_W'(1);
                    2'b01:   r_level <= r_level - LVL_W'(1);
                    default: r_level <= r_level;
                endcase
            end
        end

        // Clear beats a same-cycle increment; flushed pops are not counted.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_cnt <= '0;
            end else if (cnt_clr) begin
                r_cnt <= '0;
            end else if (w_pop && (r_cnt != {CNT_W{1'b1}})) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end

        assign drv_ready[i]                 = w_ready;
        assign obs_valid[i]                 = w_valid;
        assign obs_data[i*DATA_W +: DATA_W] = w_valid ? r_mem[r_rd_ptr] : '0;
        assign level[i*LVL_W +: LVL_W]      = r_level;
        assign xfer_cnt[i*CNT_W +: CNT_W]   = r_cnt;
    end

endmodule

// File: tb/tb_chan_link_fifo.sv
// Directed self-checking bench for chan_link_fifo; a second instance with a
// 2-bit counter shares all inputs to exercise counter saturation.
module tb_chan_link_fifo;

    localparam int unsigned NCH = 4;
    localparam int unsigned DW  = 8;
    localparam int unsigned LW  = 3;
    localparam int unsigned CW  = 8;
    localparam int unsigned SCW = 2;

    logic              clk;
    logic              rst_n;
    logic              flush;
    logic              cnt_clr;
    logic [NCH-1:0]    drv_valid;
    logic [NCH-1:0]    drv_ready;
    logic [NCH*DW-1:0] drv_data;
    logic [NCH-1:0]    obs_valid;
    logic [NCH-1:0]    obs_ready;
    logic [NCH*DW-1:0] obs_data;
    logic [NCH*LW-1:0] level;
    logic [NCH*CW-1:0] xfer_cnt;

    logic [NCH-1:0]     sat_drv_ready;
    logic [NCH-1:0]     sat_obs_valid;
    logic [NCH*DW-1:0]  sat_obs_data;
    logic [NCH*LW-1:0]  sat_level;
    logic [NCH*SCW-1:0] sat_xfer;

    int n_tests;
    int n_fail;

    chan_link_fifo #(.NUM_CH(NCH), .DATA_W(DW), .DEPTH(4), .CNT_W(CW)) u_dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .cnt_clr(cnt_clr),
        .drv_valid(drv_valid), .drv_ready(drv_ready), .drv_data(drv_data),
        .obs_valid(obs_valid), .obs_ready(obs_ready), .obs_data(obs_data),
        .level(level), .xfer_cnt(xfer_cnt)
    );

    chan_link_fifo #(.NUM_CH(NCH), .DATA_W(DW), .DEPTH(4), .CNT_W(SCW)) u_sat (
        .clk(clk), .rst_n(rst_n), .flush(flush), .cnt_clr(cnt_clr),
        .drv_valid(drv_valid), .drv_ready(sat_drv_ready), .drv_data(drv_data),
        .obs_valid(sat_obs_valid), .obs_ready(obs_ready), .obs_data(sat_obs_data),
        .level(sat_level), .xfer_cnt(sat_xfer)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] dat(input int ln);
        return obs_data[ln*DW +: DW];
    endfunction

    function automatic logic [LW-1:0] lvl(input int ln);
        return level[ln*LW +: LW];
    endfunction

    function automatic logic [CW-1:0] cnt(input int ln);
        return xfer_cnt[ln*CW +: CW];
    endfunction

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        flush     = 1'b0;
        cnt_clr   = 1'b0;
        drv_valid = '0;
        drv_data  = '0;
        obs_ready = '0;

        // Reset state
        #12;
        check("rst_obs_valid", 32'(obs_valid), 32'h0);
        check("rst_level", 32'(level), 32'h0);
        check("rst_xfer_cnt", xfer_cnt, 32'h0);
        check("rst_obs_data", obs_data, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_drv_ready", 32'(drv_ready), 32'hF);

        // Single push on lane 0, visible next cycle
        drv_valid[0]    = 1'b1;
        drv_data[7:0]   = 8'hA5;
        tick();
        drv_valid = '0;
        check("t1_obs_valid", 32'(obs_valid), 32'h1);
        check("t1_data0", 32'(dat(0)), 32'hA5);
        check("t1_level", 32'(level), 32'h001);
        obs_ready[0] = 1'b1;
        tick();
        obs_ready = '0;
        check("t1_level_after_pop", 32'(lvl(0)), 32'h0);
        check("t1_data0_empty", 32'(dat(0)), 32'h0);

        // Lane 1 fill to full, rejected push alongside pop, then drain
        for (int k = 1; k <= 4; k++) begin
            drv_valid[1]   = 1'b1;
            drv_data[15:8] = 8'(k);
            tick();
        end
        drv_valid = '0;
        check("t2_level_full", 32'(lvl(1)), 32'h4);
        check("t2_drv_ready_full", 32'(drv_ready[1]), 32'h0);
        drv_valid[1]   = 1'b1;
        drv_data[15:8] = 8'h05;
        obs_ready[1]   = 1'b1;
        #1;
        check("t2_head_01", 32'(dat(1)), 32'h01);
        tick();
        drv_valid = '0;
        check("t2_level_3", 32'(lvl(1)), 32'h3);
        for (int k = 2; k <= 4; k++) begin
            check($sformatf("t2_drain_%0d", k), 32'(dat(1)), 32'(k));
            tick();
        end
        obs_ready = '0;
        check("t2_empty_valid", 32'(obs_valid[1]), 32'h0);
        check("t2_cnt1", 32'(cnt(1)), 32'h4);

        // Lane 2 streaming push+pop, pointers wrap
        for (int k = 0; k < 10; k++) begin
            drv_valid[2]    = 1'b1;
            drv_data[23:16] = 8'(8'h10 + k);
            obs_ready[2]    = 1'b1;
            #1;
            if (k >= 1) check($sformatf("t3_head_%0d", k), 32'(dat(2)), 32'(8'h10 + k - 1));
            tick();
            check($sformatf("t3_level_%0d", k), 32'(lvl(2)), 32'h1);
        end
        drv_valid = '0;
        check("t3_cnt2", 32'(cnt(2)), 32'd9);
        check("t3_resident", 32'(dat(2)), 32'h19);
        tick();
        obs_ready = '0;
        check("t3_cnt2_final", 32'(cnt(2)), 32'd10);

        // Flush with all lanes holding 3 words
        drv_valid = 4'hF;
        drv_data  = 32'h33221100;
        for (int k = 0; k < 3; k++) tick();
        drv_valid = '0;
        check("t4_level3", 32'(level), 32'h6DB);
        flush     = 1'b1;
        drv_valid = 4'hF;
        obs_ready = 4'hF;
        #1;
        check("t4_drv_ready_flush", 32'(drv_ready), 32'h0);
        tick();
        flush     = 1'b0;
        drv_valid = '0;
        obs_ready = '0;
        #1;
        check("t4_level0", 32'(level), 32'h0);
        check("t4_obs_valid", 32'(obs_valid), 32'h0);
        check("t4_xfer_kept", xfer_cnt, 32'h000A0401);

        // Saturating 2-bit counter on lane 3
        drv_valid[3] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drv_data[31:24] = 8'(8'h40 + k);
            tick();
        end
        for (int j = 0; j < 5; j++) begin
            drv_valid[3] = (j < 2);
            obs_ready[3] = 1'b1;
            tick();
            check($sformatf("t5_sat_%0d", j), 32'(sat_xfer[3*SCW +: SCW]), (j < 2) ? 32'(j + 1) : 32'd3);
            check($sformatf("t5_sat_lvl_%0d", j), 32'(sat_level[3*LW +: LW]), (j < 2) ? 32'd3 : 32'(4 - j));
        end
        obs_ready = '0;
        check("t5_cnt3_wide", 32'(cnt(3)), 32'd5);
        drv_valid[3] = 1'b1;
        tick();
        drv_valid    = '0;
        cnt_clr      = 1'b1;
        obs_ready[3] = 1'b1;
        tick();
        cnt_clr   = 1'b0;
        obs_ready = '0;
        check("t5_clr_sat", 32'(sat_xfer), 32'h0);
        check("t5_clr_wide", xfer_cnt, 32'h0);
        check("t5_clr_popped", 32'(lvl(3)), 32'h0);
        check("t5_sat_obs_valid", 32'(sat_obs_valid), 32'h0);
        check("t5_sat_obs_data", sat_obs_data, 32'h0);
        check("t5_sat_drv_ready", 32'(sat_drv_ready), 32'hF);

        // Asynchronous reset between edges with lanes half full
        drv_valid = 4'hF;
        drv_data  = 32'hC3C2C1C0;
        tick();
        tick();
        drv_valid = '0;
        check("t6_level2", 32'(level), 32'h492);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_valid", 32'(obs_valid), 32'h0);
        check("t6_async_level", 32'(level), 32'h0);
        check("t6_async_data", obs_data, 32'h0);
        #1;
        rst_n = 1'b1;
        tick();
        check("t6_post_valid", 32'(obs_valid), 32'h0);
        check("t6_post_ready", 32'(drv_ready), 32'hF);
        drv_valid[0]  = 1'b1;
        drv_data[7:0] = 8'h77;
        tick();
        drv_valid = '0;
        check("t6_fresh_data", 32'(dat(0)), 32'h77);
        check("t6_fresh_level", 32'(level), 32'h001);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
